// File: rtl/reg_status_table.sv
// rtl/reg_status_table.sv - register result-status table for the Tomasulo issue path
//
// Purpose: resolves issuing source registers to ready values or producer tags,
// holds the operand bundle until the reservation station accepts it, records the
// accepted RS tag as the pending producer of the destination (and ICC), and
// snoops the CDB to retire pending tags into register values and ICC flags.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   issue_valid/issue_ready  issue handshake from decode
//   issue_src1/2, issue_dst  architectural register numbers
//   issue_wr, issue_cc       instruction writes issue_dst / sets ICC
//   opnd_valid, opnd_tag_k,
//   opnd_val_k               operand bundle presented to the RS
//   in_rs_enable, in_rs_tag  RS accepted the bundle with this tag
//   in_CDB_*                 common data bus snoop (tag, value, ICC flags)
//   icc_tag, icc_flags       pending ICC producer and committed flags
module reg_status_table #(
  parameter int                  NUM_REGS    = 32,
  parameter int                  TAG_W       = 5,
  parameter logic [TAG_W-1:0]    INVALID_TAG = 5'b11111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [4:0]       issue_src1,
  input  logic [4:0]       issue_src2,
  input  logic [4:0]       issue_dst,
  input  logic             issue_wr,
  input  logic             issue_cc,
  output logic             opnd_valid,
  output logic [TAG_W-1:0] opnd_tag_1,
  output logic [31:0]      opnd_val_1,
  output logic [TAG_W-1:0] opnd_tag_2,
  output logic [31:0]      opnd_val_2,
  input  logic             in_rs_enable,
  input  logic [TAG_W-1:0] in_rs_tag,
  input  logic             in_CDB_broadcast,
  input  logic [TAG_W-1:0] in_CDB_tag,
  input  logic [31:0]      in_CDB_val,
  input  logic [3:0]       in_ICC_flags,
  output logic [TAG_W-1:0] icc_tag,
  output logic [3:0]       icc_flags
);

  typedef enum logic {IDLE, WAIT_ALLOC} state_t;

  state_t             state;
  logic [31:0]        reg_val [NUM_REGS];
  logic [TAG_W-1:0]   reg_tag [NUM_REGS];
  logic [4:0]         dst_q;
  logic               wr_q;
  logic               cc_q;

  logic               cdb_hit;
  logic [TAG_W-1:0]   res_tag_1, res_tag_2;
  logic [31:0]        res_val_1, res_val_2;

  // A broadcast of INVALID_TAG would otherwise "retire" every ready register.
  assign cdb_hit = in_CDB_broadcast && (in_CDB_tag != INVALID_TAG);

  // Resolve one source against the table, bypassing a same-cycle CDB result so
  // the bundle never carries a tag whose broadcast is happening right now.
  always_comb begin
    res_tag_1 = INVALID_TAG;
    res_val_1 = '0;
    if (issue_src1 != 5'd0) begin
      if (reg_tag[issue_src1] == INVALID_TAG) begin
        res_val_1 = reg_val[issue_src1];
      end else if (cdb_hit && (in_CDB_tag == reg_tag[issue_src1])) begin
        res_val_1 = in_CDB_val;
      end else begin
        res_tag_1 = reg_tag[issue_src1];
      end
    end
  end

  always_comb begin
    res_tag_2 = INVALID_TAG;
    res_val_2 = '0;
    if (issue_src2 != 5'd0) begin
      if (reg_tag[issue_src2] == INVALID_TAG) begin
        res_val_2 = reg_val[issue_src2];
      end else if (cdb_hit && (in_CDB_tag == reg_tag[issue_src2])) begin
        res_val_2 = in_CDB_val;
      end else begin
        res_tag_2 = reg_tag[issue_src2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        reg_val[r] <= '0;
        reg_tag[r] <= INVALID_TAG;
      end
      icc_tag     <= INVALID_TAG;
      icc_flags   <= '0;
      state       <= IDLE;
      issue_ready <= 1'b1;
      opnd_valid  <= 1'b0;
      opnd_tag_1  <= '0;
      opnd_val_1  <= '0;
      opnd_tag_2  <= '0;
      opnd_val_2  <= '0;
      dst_q       <= '0;
      wr_q        <= 1'b0;
      cc_q        <= 1'b0;
    end else begin
      // CDB retirement. r0 is skipped so it can never leave its reset state.
      if (cdb_hit) begin
        for (int r = 1; r < NUM_REGS; r++) begin
          if (reg_tag[r] == in_CDB_tag) begin
            reg_val[r] <= in_CDB_val;
            reg_tag[r] <= INVALID_TAG;
          end
        end
        if (icc_tag == in_CDB_tag) begin
          icc_flags <= in_ICC_flags;
          icc_tag   <= INVALID_TAG;
        end
      end

      case (state)
        IDLE: begin
          if (issue_valid) begin
            dst_q       <= issue_dst;
            wr_q        <= issue_wr;
            cc_q        <= issue_cc;
            opnd_tag_1  <= res_tag_1;
            opnd_val_1  <= res_val_1;
            opnd_tag_2  <= res_tag_2;
            opnd_val_2  <= res_val_2;
            opnd_valid  <= 1'b1;
            issue_ready <= 1'b0;
            state       <= WAIT_ALLOC;
          end
        end
        WAIT_ALLOC: begin
          // Held operands keep snooping so the RS cannot miss a broadcast that
          // lands while the bundle is waiting.
          if (cdb_hit && (opnd_tag_1 == in_CDB_tag)) begin
            opnd_tag_1 <= INVALID_TAG;
            opnd_val_1 <= in_CDB_val;
          end
          if (cdb_hit && (opnd_tag_2 == in_CDB_tag)) begin
            opnd_tag_2 <= INVALID_TAG;
            opnd_val_2 <= in_CDB_val;
          end
          // Placed after the snoop so a new allocation overrides a same-edge
          // retirement of the old tag; the retired value is still written.
          if (in_rs_enable) begin
            if (wr_q && (dst_q != 5'd0)) begin
              reg_tag[dst_q] <= in_rs_tag;
            end
            if (cc_q) begin
              icc_tag <= in_rs_tag;
            end
            opnd_valid  <= 1'b0;
            issue_ready <= 1'b1;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
